vga_scan_compositor: RTL and testbench
======================================

Name: vga_scan_compositor

Overview:
- Display-side end of the sprite interface: 640x480@60 VGA raster timing generator.
- Drives scan coordinates to HardwareSprite instances (x_in/y_in) and consumes their pixel/d_en outputs.
- Composites sprite pixels over a background colour and drives the RGB565 and sync pins.
- Sits between the sprite layer and the board VGA DAC.

Parameters:
- INPUT_WIDTH, 10, width of coordinate outputs; must match the sprite INPUT_WIDTH.
- PIXEL_SIZE, 16, pixel width, RGB565.
- CLK_DIV, 2, clk cycles per pixel period; legal values are 2 and greater.
- H_VISIBLE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48. H_TOTAL is their sum, 800.
- V_VISIBLE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33. V_TOTAL is their sum, 525.
- TRANSPARENT_KEY, 16'hF81F, sprite colour treated as see-through.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- sprite_pixel  input  PIXEL_SIZE  pixel from sprite layer, registered by the sprite on every clk.
- sprite_d_en  input  1  sprite covers the current coordinate.
- bg_color  input  PIXEL_SIZE  background RGB565; sampled every pixel tick.
- x_out  output  INPUT_WIDTH  current horizontal count h (0..H_TOTAL-1); connects to sprite x_in.
- y_out  output  INPUT_WIDTH  current vertical count v (0..V_TOTAL-1); connects to sprite y_in.
- hsync  output  1  horizontal sync, active low.
- vsync  output  1  vertical sync, active low.
- red  output  5  pixel red.
- green  output  6  pixel green.
- blue  output  5  pixel blue.
- frame_start  output  1  one-clk pulse when the raster wraps to (0,0).

Behaviour:
- Reset (asserted asynchronously whenever rst_n=0, including mid-frame):
  - divider, h and v = 0;
  - hsync = vsync = 1;
  - red, green, blue = 0;
  - frame_start = 0.
  - After release, scanning restarts at (0,0) with a full first pixel period.
- Divider:
  - counts 0..CLK_DIV-1 and wraps;
  - tick is high in the clk cycle where divider = CLK_DIV-1.
- Counters, on each tick edge:
  - if h = H_TOTAL-1: h <= 0, and v <= (v = V_TOTAL-1) ? 0 : v+1;
  - otherwise h <= h+1.
  - Between ticks h and v hold.
  - x_out = h and y_out = v, driven straight from the registers (no combinational path).
- Sprite alignment:
  - The sprite registers its output one clk after x_out/y_out change.
  - Because CLK_DIV >= 2, sprite_pixel/sprite_d_en at a tick edge correspond to the current (h,v).
- Output stage, registered on the tick edge and held between ticks:
  - visible = (h < H_VISIBLE) and (v < V_VISIBLE).
  - If not visible: rgb = 0, even when sprite_d_en=1.
  - Else if sprite_d_en=1 and sprite_pixel != TRANSPARENT_KEY: rgb = sprite_pixel.
  - Else: rgb = bg_color.
  - Mapping: red = px[15:11], green = px[10:5], blue = px[4:0].
  - hsync = 0 iff H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC, i.e. h in 656..751.
  - vsync = 0 iff V_VISIBLE+V_FP <= v < V_VISIBLE+V_FP+V_SYNC, i.e. v in 490..491.
- Latency: rgb, hsync and vsync reflect the (h,v) held before the tick, appearing exactly one pixel period after x_out/y_out present that coordinate. Sync and colour are therefore mutually aligned.
- frame_start:
  - high for exactly one clk, on the clk after the tick edge at which h = H_TOTAL-1 and v = V_TOTAL-1;
  - at that point x_out/y_out = (0,0);
  - not asserted out of reset.
- Simultaneous events:
  - h wrap and v wrap in the same tick are handled in one update;
  - a bg_color change mid-pixel takes effect at the next tick.

Test Plan:
1. Reset values: hold rst_n=0 for 5 clk. Then assert rst_n=0 asynchronously between clk edges mid-frame (h=300, v=200). In both cases x_out=y_out=0, hsync=vsync=1, rgb=0 and frame_start=0 immediately. After release, x_out steps to 1 after exactly CLK_DIV clk.
2. Line timing, CLK_DIV=2:
   - hsync period = 1600 clk;
   - hsync low width = 192 clk;
   - first hsync low at the tick after x_out=656, i.e. lags the coordinate by 2 clk.
3. Frame timing:
   - vsync period = 840000 clk;
   - vsync low = 3200 clk (2 lines), starting one pixel period after y_out becomes 490;
   - frame_start pulses once per 840000 clk, coincident with x_out=y_out=0.
4. Compositing: bg_color=16'h001F, sprite model returns pixel 16'h07E0 with d_en=1 for x 100..131, y 50..81.
   - Pixel (100,50) outputs red=0, green=63, blue=0.
   - Pixel (99,50) outputs blue=31.
   - Both appear one pixel period after x_out/y_out present the coordinate.
5. Transparency: sprite returns 16'hF81F with d_en=1 -> output is bg_color. With bg_color=16'hFFFF, output is red=31, green=63, blue=31.
6. Blanking: force sprite_d_en=1, pixel=16'hFFFF at h=640..799 and v=480..524 -> rgb=0 throughout the blanking interval.

Source files
------------

// File: rtl/vga_scan_compositor.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_compositor
// Description : 640x480@60 VGA raster generator. Drives scan coordinates to
//               the sprite layer, composites the returned sprite pixel over a
//               background colour and drives RGB565 plus active-low syncs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_compositor #(
    parameter int          INPUT_WIDTH     = 10,
    parameter int          PIXEL_SIZE      = 16,
    parameter int          CLK_DIV         = 2,
    parameter int          H_VISIBLE       = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_VISIBLE       = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter logic [15:0] TRANSPARENT_KEY = 16'hF81F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIXEL_SIZE-1:0]  sprite_pixel,
    input  logic                   sprite_d_en,
    input  logic [PIXEL_SIZE-1:0]  bg_color,
    output logic [INPUT_WIDTH-1:0] x_out,
    output logic [INPUT_WIDTH-1:0] y_out,
    output logic                   hsync,
    output logic                   vsync,
    output logic [4:0]             red,
    output logic [5:0]             green,
    output logic [4:0]             blue,
    output logic                   frame_start
);

    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_DIV_W-1:0]     c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [INPUT_WIDTH-1:0] c_H_LAST   = INPUT_WIDTH'(c_H_TOTAL - 1);
    localparam logic [INPUT_WIDTH-1:0] c_V_LAST   = INPUT_WIDTH'(c_V_TOTAL - 1);
    localparam logic [INPUT_WIDTH-1:0] c_H_VIS    = INPUT_WIDTH'(H_VISIBLE);
    localparam logic [INPUT_WIDTH-1:0] c_V_VIS    = INPUT_WIDTH'(V_VISIBLE);
    localparam logic [INPUT_WIDTH-1:0] c_HS_START = INPUT_WIDTH'(H_VISIBLE + H_FP);
    localparam logic [INPUT_WIDTH-1:0] c_HS_END   = INPUT_WIDTH'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [INPUT_WIDTH-1:0] c_VS_START = INPUT_WIDTH'(V_VISIBLE + V_FP);
    localparam logic [INPUT_WIDTH-1:0] c_VS_END   = INPUT_WIDTH'(V_VISIBLE + V_FP + V_SYNC);

    logic [c_DIV_W-1:0]     r_div;
    logic [INPUT_WIDTH-1:0] r_h;
    logic [INPUT_WIDTH-1:0] r_v;
    logic [PIXEL_SIZE-1:0]  r_rgb;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_frame_start;

    logic                   w_tick;
    logic                   w_h_last;
    logic                   w_v_last;
    logic                   w_visible;
    logic                   w_hsync;
    logic                   w_vsync;
    logic [PIXEL_SIZE-1:0]  w_rgb;

    assign w_tick   = (r_div == c_DIV_LAST);
    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);

    // Pixel-clock divider: one tick every CLK_DIV clk cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Raster counters: h and v advance together on a line wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Colour select and sync decode for the coordinate currently presented
    always_comb begin
        w_visible = (r_h < c_H_VIS) && (r_v < c_V_VIS);
        w_hsync   = !((r_h >= c_HS_START) && (r_h < c_HS_END));
        w_vsync   = !((r_v >= c_VS_START) && (r_v < c_VS_END));
        w_rgb     = bg_color;
        if (!w_visible) begin
            w_rgb = '0;
        end else if (sprite_d_en && (sprite_pixel != TRANSPARENT_KEY)) begin
            w_rgb = sprite_pixel;
        end
    end

    // Output stage: colour and syncs register together so they stay aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_tick) begin
            r_rgb   <= w_rgb;
            r_hsync <= w_hsync;
            r_vsync <= w_vsync;
        end
    end

    // One-clk frame marker, raised as the raster wraps back to (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick && w_h_last && w_v_last;
        end
    end

    assign x_out       = r_h;
    assign y_out       = r_v;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_rgb[15:11];
    assign green       = r_rgb[10:5];
    assign blue        = r_rgb[4:0];
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_compositor
// Description : Directed self-checking bench for vga_scan_compositor using a
//               shrunken raster (30 x 19 pixel-periods, CLK_DIV=2) so whole
//               frames fit in a short run, plus a behavioural sprite model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_compositor;

    // Reduced raster: h sync low for h in 20..25, v sync low for v in 14..15
    localparam int c_HV = 16, c_HF = 4, c_HS = 6, c_HB = 4;
    localparam int c_VV = 12, c_VF = 2, c_VS = 2, c_VB = 3;
    localparam int c_DIV = 2;
    localparam int c_HT = c_HV + c_HF + c_HS + c_HB;   // 30
    localparam int c_VT = c_VV + c_VF + c_VS + c_VB;   // 19
    localparam int c_LINE_CLK  = c_HT * c_DIV;         // 60
    localparam int c_FRAME_CLK = c_HT * c_VT * c_DIV;  // 1140

    logic        clk;
    logic        rst_n;
    logic [15:0] sprite_pixel;
    logic        sprite_d_en;
    logic [15:0] bg_color;
    logic [9:0]  x_out;
    logic [9:0]  y_out;
    logic        hsync;
    logic        vsync;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic        frame_start;

    int vectors;
    int errors;
    int spr_mode;

    vga_scan_compositor #(
        .INPUT_WIDTH(10), .PIXEL_SIZE(16), .CLK_DIV(c_DIV),
        .H_VISIBLE(c_HV), .H_FP(c_HF), .H_SYNC(c_HS), .H_BP(c_HB),
        .V_VISIBLE(c_VV), .V_FP(c_VF), .V_SYNC(c_VS), .V_BP(c_VB),
        .TRANSPARENT_KEY(16'hF81F)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sprite_pixel(sprite_pixel), .sprite_d_en(sprite_d_en),
        .bg_color(bg_color),
        .x_out(x_out), .y_out(y_out),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite model: registers its answer one clk after the coordinate.
    // mode 0: no sprite; 1: green box x 5..8, y 3..5;
    // mode 2: key colour everywhere; 3: white everywhere (incl. blanking)
    always @(posedge clk) begin
        case (spr_mode)
            1: begin
                sprite_d_en  <= (x_out >= 10'd5) && (x_out <= 10'd8) &&
                                (y_out >= 10'd3) && (y_out <= 10'd5);
                sprite_pixel <= 16'h07E0;
            end
            2: begin sprite_d_en <= 1'b1; sprite_pixel <= 16'hF81F; end
            3: begin sprite_d_en <= 1'b1; sprite_pixel <= 16'hFFFF; end
            default: begin sprite_d_en <= 1'b0; sprite_pixel <= 16'h0000; end
        endcase
    end

    // Bounded search for a coordinate; returns at the first negedge it shows
    task automatic wait_coord(input int x, input int y, output bit found);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (x_out == 10'(x) && y_out == 10'(y)) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if ({x_out, y_out, hsync, vsync, red, green, blue, frame_start} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 5'd0, 6'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b, want 0 0 1 1 0000 0",
                     x_out, y_out, hsync, vsync, {red, green, blue}, frame_start);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (x_out !== 10'd0) begin
            errors++;
            $display("FAIL release_hold: x_out=%0d want 0 after 1 clk", x_out);
        end
        @(negedge clk);
        vectors++;
        if (x_out !== 10'd1) begin
            errors++;
            $display("FAIL release_step: x_out=%0d want 1 after CLK_DIV clk", x_out);
        end
    endtask

    task automatic test_line_timing();
        bit found;
        int n;
        wait_coord(20, 0, found);
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL hs_coord_timeout: x=20 never seen, want seen");
        end
        @(negedge clk);
        vectors++;
        if (hsync !== 1'b1) begin
            errors++;
            $display("FAIL hs_lag1: hsync=%b want 1 one clk after x=20", hsync);
        end
        @(negedge clk);
        vectors++;
        if (hsync !== 1'b0) begin
            errors++;
            $display("FAIL hs_lag2: hsync=%b want 0 two clk after x=20", hsync);
        end
        n = 0;
        while (hsync === 1'b0 && n < 200) begin @(negedge clk); n++; end
        vectors++;
        if (n != c_HS * c_DIV) begin
            errors++;
            $display("FAIL hs_width: low %0d clk want %0d", n, c_HS * c_DIV);
        end
        while (hsync === 1'b1 && n < 400) begin @(negedge clk); n++; end
        vectors++;
        if (n != c_LINE_CLK) begin
            errors++;
            $display("FAIL hs_period: %0d clk want %0d", n, c_LINE_CLK);
        end
    endtask

    task automatic test_frame_timing();
        bit found;
        int n;
        wait_coord(0, 14, found);
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL vs_coord_timeout: y=14 never seen, want seen");
        end
        @(negedge clk);
        vectors++;
        if (vsync !== 1'b1) begin
            errors++;
            $display("FAIL vs_lag1: vsync=%b want 1 one clk after y=14", vsync);
        end
        @(negedge clk);
        vectors++;
        if (vsync !== 1'b0) begin
            errors++;
            $display("FAIL vs_lag2: vsync=%b want 0 one pixel after y=14", vsync);
        end
        n = 0;
        while (vsync === 1'b0 && n < 2000) begin @(negedge clk); n++; end
        vectors++;
        if (n != c_VS * c_LINE_CLK) begin
            errors++;
            $display("FAIL vs_width: low %0d clk want %0d", n, c_VS * c_LINE_CLK);
        end
        while (vsync === 1'b1 && n < 3000) begin @(negedge clk); n++; end
        vectors++;
        if (n != c_FRAME_CLK) begin
            errors++;
            $display("FAIL vs_period: %0d clk want %0d", n, c_FRAME_CLK);
        end
        // frame_start: position, width and period
        n = 0;
        while (frame_start !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        vectors++;
        if (frame_start !== 1'b1 || x_out !== 10'd0 || y_out !== 10'd0) begin
            errors++;
            $display("FAIL fs_coord: fs=%b x=%0d y=%0d want 1 0 0", frame_start, x_out, y_out);
        end
        @(negedge clk);
        vectors++;
        if (frame_start !== 1'b0) begin
            errors++;
            $display("FAIL fs_width: fs=%b want 0 on second clk", frame_start);
        end
        n = 1;
        while (frame_start !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        vectors++;
        if (n != c_FRAME_CLK) begin
            errors++;
            $display("FAIL fs_period: %0d clk want %0d", n, c_FRAME_CLK);
        end
    endtask

    task automatic test_compositing();
        bit found;
        spr_mode = 1;
        bg_color = 16'h001F;
        wait_coord(4, 3, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd0, 6'd0, 5'd31}) begin
            errors++;
            $display("FAIL comp_left_bg: found=%b rgb=%0d/%0d/%0d want 0/0/31", found, red, green, blue);
        end
        wait_coord(5, 3, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd0, 6'd63, 5'd0}) begin
            errors++;
            $display("FAIL comp_sprite: found=%b rgb=%0d/%0d/%0d want 0/63/0", found, red, green, blue);
        end
        wait_coord(8, 5, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd0, 6'd63, 5'd0}) begin
            errors++;
            $display("FAIL comp_corner: found=%b rgb=%0d/%0d/%0d want 0/63/0", found, red, green, blue);
        end
        // x=9 is just past the sprite; bg changed mid-pixel lands on next tick
        wait_coord(9, 5, found);
        bg_color = 16'hF800;
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd31, 6'd0, 5'd0}) begin
            errors++;
            $display("FAIL comp_right_bg: found=%b rgb=%0d/%0d/%0d want 31/0/0", found, red, green, blue);
        end
    endtask

    task automatic test_transparency();
        bit found;
        spr_mode = 2;
        bg_color = 16'hFFFF;
        wait_coord(7, 4, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd31, 6'd63, 5'd31}) begin
            errors++;
            $display("FAIL transp_white: found=%b rgb=%0d/%0d/%0d want 31/63/31", found, red, green, blue);
        end
        bg_color = 16'h1234;
        wait_coord(2, 6, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== {5'd2, 6'd17, 5'd20}) begin
            errors++;
            $display("FAIL transp_bg: found=%b rgb=%0d/%0d/%0d want 2/17/20", found, red, green, blue);
        end
    endtask

    task automatic test_blanking();
        bit found;
        int bad;
        spr_mode = 3;
        bg_color = 16'hFFFF;
        wait_coord(2, 2, found);
        repeat (2) @(negedge clk);
        vectors++;
        if (!found || {red, green, blue} !== 16'hFFFF) begin
            errors++;
            $display("FAIL blank_visible: found=%b rgb=%h want ffff", found, {red, green, blue});
        end
        // Horizontal blanking: h = 16..29 on line 3
        wait_coord(16, 3, found);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < (c_HT - c_HV) * c_DIV; i++) begin
            if ({red, green, blue} !== 16'h0000) bad++;
            @(negedge clk);
        end
        vectors++;
        if (!found || bad != 0) begin
            errors++;
            $display("FAIL blank_h: found=%b nonzero samples=%0d want 0", found, bad);
        end
        // Vertical blanking: lines 12..18
        wait_coord(0, 12, found);
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < (c_VT - c_VV) * c_LINE_CLK; i++) begin
            if ({red, green, blue} !== 16'h0000) bad++;
            @(negedge clk);
        end
        vectors++;
        if (!found || bad != 0) begin
            errors++;
            $display("FAIL blank_v: found=%b nonzero samples=%0d want 0", found, bad);
        end
    endtask

    task automatic test_midframe_reset();
        bit found;
        spr_mode = 0;
        bg_color = 16'h001F;
        wait_coord(10, 5, found);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (!found || {x_out, y_out, hsync, vsync, red, green, blue, frame_start} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 5'd0, 6'd0, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: found=%b x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b, want 0 0 1 1 0000 0",
                     found, x_out, y_out, hsync, vsync, {red, green, blue}, frame_start);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (x_out !== 10'd0) begin
            errors++;
            $display("FAIL restart_hold: x_out=%0d want 0", x_out);
        end
        @(negedge clk);
        vectors++;
        if (x_out !== 10'd1 || y_out !== 10'd0) begin
            errors++;
            $display("FAIL restart_step: x=%0d y=%0d want 1 0", x_out, y_out);
        end
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        spr_mode = 0;
        rst_n    = 1'b0;
        bg_color = 16'h0000;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_compositing();
        test_transparency();
        test_blanking();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
